// File: rtl/simt_reconv_stack_ctrl_if.sv
// simt_reconv_stack_ctrl_if: execute-stage, push, reconverge, redirect, clear and error signals of the reconvergence stack.
// slave modport is the stack controller; master modport is the execute stage / warp context driving it.
interface simt_reconv_stack_ctrl_if #(
  parameter int NUM_WARPS   = 8,
  parameter int STACK_DEPTH = 8,
  parameter int WARP_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32
);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  logic                  rd_valid;
  logic [WW-1:0]         rd_warp_id;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic [ADDR_WIDTH-1:0] top_reconv_pc;
  logic [WARP_SIZE-1:0]  top_active_mask;
  logic [WARP_SIZE-1:0]  top_taken_mask;
  logic [DW-1:0]         top_depth;
  logic                  at_reconvergence;
  logic                  push;
  logic [WW-1:0]         push_warp_id;
  logic [ADDR_WIDTH-1:0] push_reconv_pc;
  logic [ADDR_WIDTH-1:0] push_fallthru_pc;
  logic [WARP_SIZE-1:0]  push_active_mask;
  logic [WARP_SIZE-1:0]  push_taken_mask;
  logic                  reconverge;
  logic                  redirect_valid;
  logic [WW-1:0]         redirect_warp_id;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [WARP_SIZE-1:0]  redirect_mask;
  logic                  clear;
  logic [WW-1:0]         clear_warp_id;
  logic                  overflow_err;
  logic                  underflow_err;
  logic                  err_clear;
  modport slave (
    input  rd_valid, rd_warp_id, rd_pc, push, push_warp_id, push_reconv_pc, push_fallthru_pc,
           push_active_mask, push_taken_mask, reconverge, clear, clear_warp_id, err_clear,
    output top_reconv_pc, top_active_mask, top_taken_mask, top_depth, at_reconvergence,
           redirect_valid, redirect_warp_id, redirect_pc, redirect_mask, overflow_err, underflow_err
  );
  modport master (
    output rd_valid, rd_warp_id, rd_pc, push, push_warp_id, push_reconv_pc, push_fallthru_pc,
           push_active_mask, push_taken_mask, reconverge, clear, clear_warp_id, err_clear,
    input  top_reconv_pc, top_active_mask, top_taken_mask, top_depth, at_reconvergence,
           redirect_valid, redirect_warp_id, redirect_pc, redirect_mask, overflow_err, underflow_err
  );
endinterface

// File: rtl/simt_reconv_stack_ctrl.sv
// simt_reconv_stack_ctrl: per-warp SIMT reconvergence stack with taken -> not-taken -> reconverge sequencing.
// Ports: clk, rst_n (async active-low), bus (slave modport: execute lookup, push, reconverge, redirect, clear, errors).
module simt_reconv_stack_ctrl #(
  parameter int NUM_WARPS   = 8,
  parameter int STACK_DEPTH = 8,
  parameter int WARP_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input logic clk,
  input logic rst_n,
  simt_reconv_stack_ctrl_if.slave bus
);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int DW = IW + 1;
  logic [ADDR_WIDTH-1:0] rpc_q [NUM_WARPS][STACK_DEPTH], rpc_d [NUM_WARPS][STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] ft_q  [NUM_WARPS][STACK_DEPTH], ft_d  [NUM_WARPS][STACK_DEPTH];
  logic [WARP_SIZE-1:0]  act_q [NUM_WARPS][STACK_DEPTH], act_d [NUM_WARPS][STACK_DEPTH];
  logic [WARP_SIZE-1:0]  tk_q  [NUM_WARPS][STACK_DEPTH], tk_d  [NUM_WARPS][STACK_DEPTH];
  logic [STACK_DEPTH-1:0] phase_q [NUM_WARPS], phase_d [NUM_WARPS];
  logic [DW-1:0]          depth_q [NUM_WARPS], depth_d [NUM_WARPS];
  logic                  rv_q, rv_d, ovf_q, ovf_d, unf_q, unf_d, ovf_set, unf_set;
  logic [WW-1:0]         rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] rpco_q, rpco_d;
  logic [WARP_SIZE-1:0]  rmask_q, rmask_d, nt;
  logic [DW-1:0]         rd_depth, pd;
  logic [IW-1:0]         ridx;
  logic                  rd_empty;
  assign rd_depth = depth_q[bus.rd_warp_id];
  assign rd_empty = rd_depth == '0;
  assign ridx     = IW'(rd_depth - DW'(1));
  assign nt       = act_q[bus.rd_warp_id][ridx] & ~tk_q[bus.rd_warp_id][ridx];
  assign bus.top_depth        = rd_depth;
  assign bus.top_reconv_pc    = rd_empty ? '0 : rpc_q[bus.rd_warp_id][ridx];
  assign bus.top_active_mask  = rd_empty ? '0 : act_q[bus.rd_warp_id][ridx];
  assign bus.top_taken_mask   = rd_empty ? '0 : tk_q[bus.rd_warp_id][ridx];
  assign bus.at_reconvergence = bus.rd_valid && !rd_empty && bus.rd_pc == rpc_q[bus.rd_warp_id][ridx];
  assign bus.redirect_valid   = rv_q;
  assign bus.redirect_warp_id = rw_q;
  assign bus.redirect_pc      = rpco_q;
  assign bus.redirect_mask    = rmask_q;
  assign bus.overflow_err     = ovf_q;
  assign bus.underflow_err    = unf_q;
  always_comb begin
    rpc_d = rpc_q;
    ft_d = ft_q;
    act_d = act_q;
    tk_d = tk_q;
    phase_d = phase_q;
    depth_d = depth_q;
    rv_d = 1'b0;
    rw_d = rw_q;
    rpco_d = rpco_q;
    rmask_d = rmask_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    // A same-warp clear discards the reconverge entirely, including its underflow.
    if (bus.reconverge && !(bus.clear && bus.clear_warp_id == bus.rd_warp_id)) begin
      if (rd_empty) unf_set = 1'b1;
      else begin
        rv_d = 1'b1;
        rw_d = bus.rd_warp_id;
        if (!phase_q[bus.rd_warp_id][ridx] && nt != '0) begin
          phase_d[bus.rd_warp_id][ridx] = 1'b1;
          rpco_d = ft_q[bus.rd_warp_id][ridx];
          rmask_d = nt;
        end else begin
          depth_d[bus.rd_warp_id] = rd_depth - DW'(1);
          rpco_d = rpc_q[bus.rd_warp_id][ridx];
          rmask_d = act_q[bus.rd_warp_id][ridx];
        end
      end
    end
    // Push sees the post-reconverge depth so a pop frees the slot it writes.
    pd = depth_d[bus.push_warp_id];
    if (bus.push && !(bus.clear && bus.clear_warp_id == bus.push_warp_id)) begin
      if (pd == DW'(STACK_DEPTH)) ovf_set = 1'b1;
      else begin
        rpc_d[bus.push_warp_id][pd[IW-1:0]] = bus.push_reconv_pc;
        ft_d[bus.push_warp_id][pd[IW-1:0]] = bus.push_fallthru_pc;
        act_d[bus.push_warp_id][pd[IW-1:0]] = bus.push_active_mask;
        tk_d[bus.push_warp_id][pd[IW-1:0]] = bus.push_taken_mask;
        phase_d[bus.push_warp_id][pd[IW-1:0]] = 1'b0;
        depth_d[bus.push_warp_id] = pd + DW'(1);
      end
    end
    if (bus.clear) depth_d[bus.clear_warp_id] = '0;
    ovf_d = !bus.err_clear && (ovf_q || ovf_set);
    unf_d = !bus.err_clear && (unf_q || unf_set);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '{default: '0};
      phase_q <= '{default: '0};
      rv_q <= 1'b0;
      rw_q <= '0;
      rpco_q <= '0;
      rmask_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      phase_q <= phase_d;
      rv_q <= rv_d;
      rw_q <= rw_d;
      rpco_q <= rpco_d;
      rmask_q <= rmask_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Entry payload is only observable below depth, so it needs no reset.
  always_ff @(posedge clk) begin
    rpc_q <= rpc_d;
    ft_q <= ft_d;
    act_q <= act_d;
    tk_q <= tk_d;
  end
endmodule

// File: tb/tb_simt_reconv_stack_ctrl.sv
// tb_simt_reconv_stack_ctrl: directed and randomized checks of the reconvergence stack against a queue model.
module tb_simt_reconv_stack_ctrl;
  localparam int NW = 8, SD = 8, WS = 32, AW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  simt_reconv_stack_ctrl_if #(.NUM_WARPS(NW), .STACK_DEPTH(SD), .WARP_SIZE(WS), .ADDR_WIDTH(AW)) bus ();
  simt_reconv_stack_ctrl #(.NUM_WARPS(NW), .STACK_DEPTH(SD), .WARP_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  typedef struct {
    logic [AW-1:0] rpc;
    logic [AW-1:0] ft;
    logic [WS-1:0] act;
    logic [WS-1:0] tk;
    bit            ph;
  } ent_t;
  ent_t stk [NW][$];
  bit m_ovf, m_unf, m_rv;
  logic [2:0] m_rw;
  logic [AW-1:0] m_pc;
  logic [WS-1:0] m_mask;
  int n = 0, fails = 0;
  task automatic model_reset();
    for (int w = 0; w < NW; w++) stk[w].delete();
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rw = '0; m_pc = '0; m_mask = '0;
  endtask
  // Applies the current inputs to the model as one clock edge would.
  task automatic model_step();
    int rw, pw, cw;
    bit ov, un;
    ent_t e, p;
    logic [WS-1:0] ntm;
    rw = int'(bus.rd_warp_id); pw = int'(bus.push_warp_id); cw = int'(bus.clear_warp_id);
    ov = 0; un = 0; m_rv = 0;
    if (bus.reconverge && !(bus.clear && cw == rw)) begin
      if (stk[rw].size() == 0) un = 1;
      else begin
        e = stk[rw].pop_back();
        ntm = e.act & ~e.tk;
        m_rv = 1; m_rw = bus.rd_warp_id;
        if (!e.ph && ntm != '0) begin
          e.ph = 1; stk[rw].push_back(e); m_pc = e.ft; m_mask = ntm;
        end else begin
          m_pc = e.rpc; m_mask = e.act;
        end
      end
    end
    if (bus.push && !(bus.clear && cw == pw)) begin
      if (stk[pw].size() == SD) ov = 1;
      else begin
        p.rpc = bus.push_reconv_pc; p.ft = bus.push_fallthru_pc;
        p.act = bus.push_active_mask; p.tk = bus.push_taken_mask; p.ph = 0;
        stk[pw].push_back(p);
      end
    end
    if (bus.clear) stk[cw].delete();
    m_ovf = bus.err_clear ? 0 : (m_ovf | ov);
    m_unf = bus.err_clear ? 0 : (m_unf | un);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.push = 0; bus.reconverge = 0; bus.clear = 0; bus.err_clear = 0;
  endtask
  task automatic set_push(input int w, input logic [AW-1:0] rpc, input logic [AW-1:0] ft,
                          input logic [WS-1:0] act, input logic [WS-1:0] tk);
    bus.push = 1; bus.push_warp_id = 3'(w); bus.push_reconv_pc = rpc;
    bus.push_fallthru_pc = ft; bus.push_active_mask = act; bus.push_taken_mask = tk;
  endtask
  task automatic set_rd(input int w, input logic [AW-1:0] pc);
    bus.rd_valid = 1; bus.rd_warp_id = 3'(w); bus.rd_pc = pc;
  endtask
  task automatic test_reset();
    rst_n = 0;
    bus.rd_valid = 0; bus.rd_warp_id = '0; bus.rd_pc = '0;
    bus.push = 0; bus.push_warp_id = '0; bus.push_reconv_pc = '0; bus.push_fallthru_pc = '0;
    bus.push_active_mask = '0; bus.push_taken_mask = '0;
    bus.reconverge = 0; bus.clear = 0; bus.clear_warp_id = '0; bus.err_clear = 0;
    model_reset();
    #12;
    for (int w = 0; w < NW; w++) begin
      bus.rd_warp_id = 3'(w);
      #1;
      n++;
      if (bus.top_depth !== 4'd0 || bus.top_reconv_pc !== '0 || bus.top_active_mask !== '0 || bus.top_taken_mask !== '0) begin
        fails++;
        $display("FAIL reset_top w%0d: depth=%0d rpc=%h act=%h tk=%h, required all 0", w,
                 bus.top_depth, bus.top_reconv_pc, bus.top_active_mask, bus.top_taken_mask);
      end
    end
    n++;
    if (bus.redirect_valid !== 1'b0 || bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: rv=%b ovf=%b unf=%b, required 0 0 0", bus.redirect_valid, bus.overflow_err, bus.underflow_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_basic();
    set_push(2, 32'h100, 32'h40, 32'hFFFF_FFFF, 32'h0000_FFFF);
    set_rd(2, 32'h100);
    tick();
    n++;
    if (bus.at_reconvergence !== 1'b1 || bus.top_depth !== 4'd1 || bus.top_taken_mask !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL basic_top: at=%b depth=%0d tk=%h, required 1 1 0000ffff", bus.at_reconvergence, bus.top_depth, bus.top_taken_mask);
    end
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.redirect_mask !== 32'hFFFF_0000 ||
        bus.redirect_warp_id !== 3'd2 || bus.top_depth !== 4'd1) begin
      fails++;
      $display("FAIL basic_nt: rv=%b pc=%h mask=%h w=%0d depth=%0d, required 1 40 ffff0000 2 1",
               bus.redirect_valid, bus.redirect_pc, bus.redirect_mask, bus.redirect_warp_id, bus.top_depth);
    end
    tick();
    n++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h40) begin
      fails++;
      $display("FAIL basic_hold: rv=%b pc=%h, required 0 40", bus.redirect_valid, bus.redirect_pc);
    end
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100 || bus.redirect_mask !== 32'hFFFF_FFFF ||
        bus.top_depth !== 4'd0 || bus.at_reconvergence !== 1'b0) begin
      fails++;
      $display("FAIL basic_pop: rv=%b pc=%h mask=%h depth=%0d at=%b, required 1 100 ffffffff 0 0",
               bus.redirect_valid, bus.redirect_pc, bus.redirect_mask, bus.top_depth, bus.at_reconvergence);
    end
  endtask
  task automatic test_nested();
    set_rd(0, 32'h0);
    set_push(0, 32'h200, 32'h180, 32'hFF, 32'h0F);
    tick();
    set_push(0, 32'h300, 32'h280, 32'h0F, 32'h03);
    tick();
    n++;
    if (bus.top_depth !== 4'd2 || bus.top_reconv_pc !== 32'h300 || bus.top_active_mask !== 32'h0F) begin
      fails++;
      $display("FAIL nested_push: depth=%0d rpc=%h act=%h, required 2 300 0f", bus.top_depth, bus.top_reconv_pc, bus.top_active_mask);
    end
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_pc !== 32'h280 || bus.redirect_mask !== 32'h0C || bus.top_depth !== 4'd2) begin
      fails++;
      $display("FAIL nested_nt: pc=%h mask=%h depth=%0d, required 280 0c 2", bus.redirect_pc, bus.redirect_mask, bus.top_depth);
    end
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_pc !== 32'h300 || bus.redirect_mask !== 32'h0F || bus.top_depth !== 4'd1 || bus.top_reconv_pc !== 32'h200) begin
      fails++;
      $display("FAIL nested_pop: pc=%h mask=%h depth=%0d rpc=%h, required 300 0f 1 200",
               bus.redirect_pc, bus.redirect_mask, bus.top_depth, bus.top_reconv_pc);
    end
    bus.clear = 1; bus.clear_warp_id = 3'd0;
    tick();
  endtask
  task automatic test_overflow();
    set_rd(5, 32'h0);
    for (int i = 0; i < SD; i++) begin
      set_push(5, 32'h500 + 32'(i), 32'h10, 32'hF, 32'h1);
      tick();
    end
    n++;
    if (bus.top_depth !== 4'd8 || bus.overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_full: depth=%0d ovf=%b, required 8 0", bus.top_depth, bus.overflow_err);
    end
    set_push(5, 32'hDEAD, 32'h10, 32'hF, 32'h1);
    tick();
    n++;
    if (bus.top_depth !== 4'd8 || bus.overflow_err !== 1'b1 || bus.top_reconv_pc !== 32'h507) begin
      fails++;
      $display("FAIL ovf_set: depth=%0d ovf=%b rpc=%h, required 8 1 507", bus.top_depth, bus.overflow_err, bus.top_reconv_pc);
    end
    bus.err_clear = 1;
    tick();
    n++;
    if (bus.overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b, required 0", bus.overflow_err);
    end
    set_push(5, 32'hBEEF, 32'h10, 32'hF, 32'h1);
    bus.err_clear = 1;
    tick();
    n++;
    if (bus.overflow_err !== 1'b0 || bus.top_depth !== 4'd8) begin
      fails++;
      $display("FAIL ovf_clear_prio: ovf=%b depth=%0d, required 0 8", bus.overflow_err, bus.top_depth);
    end
    bus.clear = 1; bus.clear_warp_id = 3'd5;
    tick();
  endtask
  task automatic test_underflow();
    set_rd(3, 32'h0);
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_valid !== 1'b0 || bus.underflow_err !== 1'b1 || bus.top_depth !== 4'd0) begin
      fails++;
      $display("FAIL underflow: rv=%b unf=%b depth=%0d, required 0 1 0", bus.redirect_valid, bus.underflow_err, bus.top_depth);
    end
    bus.err_clear = 1;
    tick();
    n++;
    if (bus.underflow_err !== 1'b0) begin
      fails++;
      $display("FAIL unf_clear: unf=%b, required 0", bus.underflow_err);
    end
  endtask
  task automatic test_simultaneous();
    set_rd(1, 32'h0);
    for (int i = 0; i < SD; i++) begin
      set_push(1, 32'h1000 + 32'(i), 32'h800 + 32'(i), 32'hFF, 32'h0F);
      tick();
    end
    bus.reconverge = 1;
    tick();
    n++;
    if (bus.redirect_pc !== 32'h807 || bus.redirect_mask !== 32'hF0 || bus.top_depth !== 4'd8) begin
      fails++;
      $display("FAIL sim_flip: pc=%h mask=%h depth=%0d, required 807 f0 8", bus.redirect_pc, bus.redirect_mask, bus.top_depth);
    end
    bus.reconverge = 1;
    set_push(1, 32'h2000, 32'h2100, 32'h3, 32'h1);
    tick();
    n++;
    if (bus.top_depth !== 4'd8 || bus.overflow_err !== 1'b0 || bus.redirect_valid !== 1'b1 ||
        bus.redirect_pc !== 32'h1007 || bus.redirect_mask !== 32'hFF || bus.top_reconv_pc !== 32'h2000) begin
      fails++;
      $display("FAIL sim_pop_push: depth=%0d ovf=%b rv=%b pc=%h mask=%h top=%h, required 8 0 1 1007 ff 2000",
               bus.top_depth, bus.overflow_err, bus.redirect_valid, bus.redirect_pc, bus.redirect_mask, bus.top_reconv_pc);
    end
    bus.reconverge = 1;
    bus.clear = 1; bus.clear_warp_id = 3'd1;
    set_push(1, 32'h3000, 32'h3100, 32'h3, 32'h1);
    tick();
    n++;
    if (bus.top_depth !== 4'd0 || bus.redirect_valid !== 1'b0 || bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL sim_clear: depth=%0d rv=%b unf=%b ovf=%b, required 0 0 0 0",
               bus.top_depth, bus.redirect_valid, bus.underflow_err, bus.overflow_err);
    end
    set_rd(6, 32'h0);
    set_push(6, 32'h600, 32'h610, 32'hFF, 32'h0F);
    tick();
    bus.reconverge = 1;
    set_push(6, 32'h700, 32'h710, 32'hF0, 32'h30);
    tick();
    n++;
    if (bus.top_depth !== 4'd2 || bus.top_reconv_pc !== 32'h700 || bus.redirect_pc !== 32'h610) begin
      fails++;
      $display("FAIL sim_flip_push: depth=%0d top=%h pc=%h, required 2 700 610", bus.top_depth, bus.top_reconv_pc, bus.redirect_pc);
    end
    bus.clear = 1; bus.clear_warp_id = 3'd6;
    tick();
  endtask
  task automatic test_async_reset();
    set_rd(4, 32'h0);
    set_push(4, 32'h400, 32'h410, 32'hF, 32'h3);
    tick();
    bus.reconverge = 1;
    tick();
    rst_n = 0;
    #1;
    n++;
    if (bus.redirect_valid !== 1'b0 || bus.top_depth !== 4'd0 || bus.redirect_pc !== '0) begin
      fails++;
      $display("FAIL async_reset: rv=%b depth=%0d pc=%h, required 0 0 0", bus.redirect_valid, bus.top_depth, bus.redirect_pc);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_random();
    int rw, sz;
    logic [WS-1:0] a;
    logic [AW-1:0] exp_rpc;
    logic [WS-1:0] exp_act, exp_tk;
    bit exp_at;
    for (int it = 0; it < 400; it++) begin
      rw = int'($urandom_range(0, 3));
      sz = stk[rw].size();
      bus.rd_valid = 1'($urandom_range(0, 3) != 0);
      bus.rd_warp_id = 3'(rw);
      bus.rd_pc = (sz > 0 && $urandom_range(0, 1) == 1) ? stk[rw][sz-1].rpc : 32'($urandom_range(0, 15));
      a = $urandom();
      bus.push = 1'($urandom_range(0, 1));
      bus.push_warp_id = 3'($urandom_range(0, 3));
      bus.push_reconv_pc = 32'($urandom_range(0, 15));
      bus.push_fallthru_pc = $urandom();
      bus.push_active_mask = a;
      bus.push_taken_mask = ($urandom_range(0, 3) == 0) ? a : (a & $urandom());
      bus.reconverge = 1'($urandom_range(0, 9) < 4);
      bus.clear = 1'($urandom_range(0, 9) == 0);
      bus.clear_warp_id = 3'($urandom_range(0, 3));
      bus.err_clear = 1'($urandom_range(0, 19) == 0);
      #1;
      exp_rpc = sz > 0 ? stk[rw][sz-1].rpc : '0;
      exp_act = sz > 0 ? stk[rw][sz-1].act : '0;
      exp_tk = sz > 0 ? stk[rw][sz-1].tk : '0;
      exp_at = bus.rd_valid && sz > 0 && bus.rd_pc == exp_rpc;
      n++;
      if (bus.top_depth !== 4'(sz) || bus.top_reconv_pc !== exp_rpc || bus.top_active_mask !== exp_act ||
          bus.top_taken_mask !== exp_tk || bus.at_reconvergence !== exp_at) begin
        fails++;
        $display("FAIL rand_top it%0d: depth=%0d rpc=%h act=%h tk=%h at=%b, required %0d %h %h %h %b", it,
                 bus.top_depth, bus.top_reconv_pc, bus.top_active_mask, bus.top_taken_mask, bus.at_reconvergence,
                 sz, exp_rpc, exp_act, exp_tk, exp_at);
      end
      tick();
      n++;
      if (bus.redirect_valid !== m_rv || bus.redirect_pc !== m_pc || bus.redirect_mask !== m_mask ||
          bus.redirect_warp_id !== m_rw || bus.overflow_err !== m_ovf || bus.underflow_err !== m_unf) begin
        fails++;
        $display("FAIL rand_redir it%0d: rv=%b pc=%h mask=%h w=%0d ovf=%b unf=%b, required %b %h %h %0d %b %b", it,
                 bus.redirect_valid, bus.redirect_pc, bus.redirect_mask, bus.redirect_warp_id, bus.overflow_err,
                 bus.underflow_err, m_rv, m_pc, m_mask, m_rw, m_ovf, m_unf);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
